param_readback_tx: RTL and testbench
====================================

PARAM_READBACK_TX -- requirements
Module: param_readback_tx

Interface
REQ-001 Parameter HEADER, default 8'h01, SHALL be the first byte of a valid-code response frame.
REQ-002 Parameter NAK, default 8'hEE, SHALL be the first byte of an unknown-code response frame.
REQ-003 clk  input  1  SHALL be the single clock; all logic is clocked on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req  input  1  SHALL request one response frame; it is sampled only in IDLE.
REQ-006 req_code  input  16  SHALL carry the register code to read back, using the same code map as the command parser.
REQ-007 Inputs freq_sync, delay_pulse, width_pulse, delay_det, width_det, ireg_read and ireg_write (32 each), pixelColor (64), estadoRx, controlDM and dead_time_APD (8 each), and dataPoints (16) SHALL be the live parameter values.
REQ-008 tx_busy  input  1  SHALL be the UART transmitter busy flag.
REQ-009 tx_data  output  8  SHALL carry the byte for the UART transmitter.
REQ-010 tx_start  output  1  SHALL be a one-cycle pulse that starts transmission of tx_data.
REQ-011 busy  output  1  SHALL be high from request acceptance until frame completion.
REQ-012 done  output  1  SHALL be a one-cycle pulse after the last byte has finished.

Function
REQ-013 Frame SHALL be 11 bytes: head, d8..d1 (64-bit value, MSB first), code[15:8], code[7:0]; this mirrors the inbound command frame.
REQ-014 Value mapping SHALL be zero-extended into 64 bits:
- 20 -> estadoRx
- 25 -> controlDM
- 26..30 -> freq_sync, delay_pulse, width_pulse, delay_det, width_det
- 33 -> pixelColor
- 35 -> ireg_write
- 36 -> ireg_read
- 41 -> dead_time_APD
- 42 -> dataPoints
REQ-015 Any other code SHALL produce head=NAK, a value of 0, and the requested code echoed in the code bytes.
REQ-016 On req in IDLE, the block SHALL latch req_code and the mapped value on that same edge (a snapshot), so later input changes do not alter the frame.
REQ-017 State machine SHALL be IDLE -> LOAD -> START -> WAIT_HI -> WAIT_LO -> (START for the next byte | DONE) -> IDLE.
REQ-018 START SHALL drive tx_data and pulse tx_start for exactly one cycle.
REQ-019 tx_data SHALL be held stable from START until WAIT_LO exits.
REQ-020 WAIT_HI SHALL wait for tx_busy=1, and WAIT_LO SHALL wait for tx_busy=0; no byte is started while tx_busy=1.
REQ-021 tx_busy already high at START SHALL be accepted as WAIT_HI satisfied on the following cycle.
REQ-022 The byte index counter SHALL run 0..LAST and SHALL reset to 0 in LOAD; it never wraps within a frame.
REQ-023 req asserted while busy=1 SHALL be ignored; it is not queued.
REQ-024 done SHALL be asserted in DONE for one cycle; busy SHALL fall on the same edge that done rises.
REQ-025 req held high continuously SHALL produce back-to-back frames, with at least one IDLE cycle between them.
REQ-026 Latency from the req edge to the first tx_start SHALL be 2 cycles (LOAD, START).

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, tx_start=0, tx_data=8'h00, busy=0, done=0, byte index=0, and clear the latched code and value.
REQ-028 Reset in the middle of a frame SHALL abandon the frame; no further tx_start is issued and no done pulse is produced.

Configuration
REQ-029 With PARAM_TX_CHECKSUM_EN defined, a 12th byte equal to the XOR of bytes 1..11 SHALL be appended (LAST=11).
REQ-030 Without PARAM_TX_CHECKSUM_EN, the frame SHALL be 11 bytes (LAST=10) and no checksum logic SHALL be present.

Structure
REQ-031 Register code constants (20..42), the frame length constants and the HEADER/NAK defaults SHALL live in the shared package param_pkg, which the command parser also uses.
REQ-032 Value selection SHALL be a sub-module param_readback_mux (code -> 64-bit value plus a valid flag); the sequencer SHALL remain in the top level.

Verification
REQ-033 freq_sync=32'h0000_C350, req_code=26, with a transmitter model of 3-cycle busy -> bytes 01,00,00,00,00,00,00,C3,50,00,1A, followed by one done pulse.
REQ-034 req_code=33, pixelColor=64'h0123_4567_89AB_CDEF -> bytes 01,01,23,45,67,89,AB,CD,EF,00,21.
REQ-035 req_code=16'h0063 -> bytes EE,00×8,00,63.
REQ-036 Second req asserted on byte 4 of a frame -> ignored, and exactly 11 tx_start pulses are produced.
REQ-037 rst_n=0 after the 5th tx_start -> tx_start, busy and done are all 0 and stay 0; a subsequent req produces a complete frame.
REQ-038 With PARAM_TX_CHECKSUM_EN defined, req_code=20, estadoRx=8'h05 -> 12th byte = 01^05^00^14 = 8'h10.

Source files
------------

// File: rtl/param_pkg.sv
// param_pkg -- constants shared by the parameter command parser and the
// parameter read-back transmitter.
//   * register code map (codes 20..42)
//   * outbound frame length (FRAME_LAST = index of the final byte)
//   * default first bytes for known-code and unknown-code responses
//   * read-back sequencer state encoding
// Optional build macro: PARAM_TX_CHECKSUM_EN appends an XOR checksum byte.
package param_pkg;

    localparam logic [15:0] CODE_ESTADO_RX     = 16'd20;
    localparam logic [15:0] CODE_CONTROL_DM    = 16'd25;
    localparam logic [15:0] CODE_FREQ_SYNC     = 16'd26;
    localparam logic [15:0] CODE_DELAY_PULSE   = 16'd27;
    localparam logic [15:0] CODE_WIDTH_PULSE   = 16'd28;
    localparam logic [15:0] CODE_DELAY_DET     = 16'd29;
    localparam logic [15:0] CODE_WIDTH_DET     = 16'd30;
    localparam logic [15:0] CODE_PIXEL_COLOR   = 16'd33;
    localparam logic [15:0] CODE_IREG_WRITE    = 16'd35;
    localparam logic [15:0] CODE_IREG_READ     = 16'd36;
    localparam logic [15:0] CODE_DEAD_TIME_APD = 16'd41;
    localparam logic [15:0] CODE_DATA_POINTS   = 16'd42;

    localparam logic [7:0] HEADER_DEFAULT = 8'h01;
    localparam logic [7:0] NAK_DEFAULT    = 8'hEE;

    localparam int unsigned IDX_W = 4;

`ifdef PARAM_TX_CHECKSUM_EN
    localparam logic [IDX_W-1:0] FRAME_LAST = 4'd11;
`else
    localparam logic [IDX_W-1:0] FRAME_LAST = 4'd10;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } tx_state_e;

endpackage

// File: rtl/param_readback_mux.sv
// param_readback_mux -- selects the live parameter addressed by a register
// code and zero-extends it to 64 bits.
// Ports:
//   code            in  16  register code
//   freq_sync .. dataPoints  in  live parameter values
//   value           out 64  selected value (0 for unknown codes)
//   valid           out 1   code is part of the read-back map
module param_readback_mux
    import param_pkg::*;
(
    input  logic [15:0] code,
    input  logic [31:0] freq_sync,
    input  logic [31:0] delay_pulse,
    input  logic [31:0] width_pulse,
    input  logic [31:0] delay_det,
    input  logic [31:0] width_det,
    input  logic [31:0] ireg_read,
    input  logic [31:0] ireg_write,
    input  logic [63:0] pixelColor,
    input  logic [7:0]  estadoRx,
    input  logic [7:0]  controlDM,
    input  logic [7:0]  dead_time_APD,
    input  logic [15:0] dataPoints,
    output logic [63:0] value,
    output logic        valid
);

    always_comb begin
        value = 64'd0;
        valid = 1'b1;
        case (code)
            CODE_ESTADO_RX:     value = {56'd0, estadoRx};
            CODE_CONTROL_DM:    value = {56'd0, controlDM};
            CODE_FREQ_SYNC:     value = {32'd0, freq_sync};
            CODE_DELAY_PULSE:   value = {32'd0, delay_pulse};
            CODE_WIDTH_PULSE:   value = {32'd0, width_pulse};
            CODE_DELAY_DET:     value = {32'd0, delay_det};
            CODE_WIDTH_DET:     value = {32'd0, width_det};
            CODE_PIXEL_COLOR:   value = pixelColor;
            CODE_IREG_WRITE:    value = {32'd0, ireg_write};
            CODE_IREG_READ:     value = {32'd0, ireg_read};
            CODE_DEAD_TIME_APD: value = {56'd0, dead_time_APD};
            CODE_DATA_POINTS:   value = {48'd0, dataPoints};
            default:            valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/param_readback_tx.sv
// param_readback_tx -- on request, snapshots one parameter and sends it to a
// byte-wide UART transmitter as a response frame:
//   head, value[63:0] MSB first, code[15:8], code[7:0] (+ XOR checksum when
//   PARAM_TX_CHECKSUM_EN is defined).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req, req_code     frame request and register code (sampled in IDLE only)
//   freq_sync .. dataPoints  live parameter values
//   tx_busy           UART transmitter busy
//   tx_data, tx_start byte to send and its one-cycle start strobe
//   busy, done        frame in progress / one-cycle frame-complete pulse
// Parameters: HEADER (known code first byte), NAK (unknown code first byte).
module param_readback_tx
    import param_pkg::*;
#(
    parameter logic [7:0] HEADER = HEADER_DEFAULT,
    parameter logic [7:0] NAK    = NAK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] req_code,
    input  logic [31:0] freq_sync,
    input  logic [31:0] delay_pulse,
    input  logic [31:0] width_pulse,
    input  logic [31:0] delay_det,
    input  logic [31:0] width_det,
    input  logic [31:0] ireg_read,
    input  logic [31:0] ireg_write,
    input  logic [63:0] pixelColor,
    input  logic [7:0]  estadoRx,
    input  logic [7:0]  controlDM,
    input  logic [7:0]  dead_time_APD,
    input  logic [15:0] dataPoints,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        busy,
    output logic        done
);

    tx_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       code_q, code_d;
    logic [63:0]       value_q, value_d;
    logic              nak_q, nak_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [63:0]       mux_value;
    logic              mux_valid;
    logic [7:0]        head;
    logic [7:0]        csum;

    param_readback_mux u_mux (
        .code          (req_code),
        .freq_sync     (freq_sync),
        .delay_pulse   (delay_pulse),
        .width_pulse   (width_pulse),
        .delay_det     (delay_det),
        .width_det     (width_det),
        .ireg_read     (ireg_read),
        .ireg_write    (ireg_write),
        .pixelColor    (pixelColor),
        .estadoRx      (estadoRx),
        .controlDM     (controlDM),
        .dead_time_APD (dead_time_APD),
        .dataPoints    (dataPoints),
        .value         (mux_value),
        .valid         (mux_valid)
    );

    // Unknown codes latch a zero value from the mux, so only the head differs.
    assign head = nak_q ? NAK : HEADER;

`ifdef PARAM_TX_CHECKSUM_EN
    always_comb begin
        csum = head ^ code_q[15:8] ^ code_q[7:0];
        for (int k = 0; k < 8; k++) begin
            csum = csum ^ value_q[k*8 +: 8];
        end
    end
`else
    assign csum = 8'h00;
`endif

    // Index 11 only exists with the checksum build; otherwise it is never
    // reached and csum is a constant.
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] i);
        case (i)
            4'd0:    return head;
            4'd1:    return value_q[63:56];
            4'd2:    return value_q[55:48];
            4'd3:    return value_q[47:40];
            4'd4:    return value_q[39:32];
            4'd5:    return value_q[31:24];
            4'd6:    return value_q[23:16];
            4'd7:    return value_q[15:8];
            4'd8:    return value_q[7:0];
            4'd9:    return code_q[15:8];
            4'd10:   return code_q[7:0];
            default: return csum;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        code_d     = code_q;
        value_d    = value_q;
        nak_d      = nak_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    // Snapshot on the accepting edge; later input changes
                    // must not leak into this frame.
                    code_d  = req_code;
                    value_d = mux_value;
                    nak_d   = ~mux_valid;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_d      = '0;
                tx_data_d  = frame_byte('0);
                tx_start_d = 1'b1;
                state_d    = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx_q == FRAME_LAST) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d      = idx_q + 4'd1;
                        tx_data_d  = frame_byte(idx_q + 4'd1);
                        tx_start_d = 1'b1;
                        state_d    = ST_START;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            code_q     <= 16'h0000;
            value_q    <= 64'd0;
            nak_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            code_q     <= code_d;
            value_q    <= value_d;
            nak_q      <= nak_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_param_readback_tx.sv
// Testbench for param_readback_tx: directed requests against a UART
// transmitter model (3-cycle busy), with a frame model and a per-cycle
// monitor comparing every transmitted byte and completion pulse.
module tb_param_readback_tx;

`ifdef PARAM_TX_CHECKSUM_EN
    localparam int FRAME_N = 12;
`else
    localparam int FRAME_N = 11;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [15:0] req_code = 16'h0000;
    logic [31:0] freq_sync = 32'h0, delay_pulse = 32'h0, width_pulse = 32'h0;
    logic [31:0] delay_det = 32'h0, width_det = 32'h0;
    logic [31:0] ireg_read = 32'h0, ireg_write = 32'h0;
    logic [63:0] pixelColor = 64'h0;
    logic [7:0]  estadoRx = 8'h0, controlDM = 8'h0, dead_time_APD = 8'h0;
    logic [15:0] dataPoints = 16'h0;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_start, busy, done;

    always #5 clk = ~clk;

    param_readback_tx dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_code(req_code),
        .freq_sync(freq_sync), .delay_pulse(delay_pulse),
        .width_pulse(width_pulse), .delay_det(delay_det),
        .width_det(width_det), .ireg_read(ireg_read),
        .ireg_write(ireg_write), .pixelColor(pixelColor),
        .estadoRx(estadoRx), .controlDM(controlDM),
        .dead_time_APD(dead_time_APD), .dataPoints(dataPoints),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
        .busy(busy), .done(done)
    );

    // UART transmitter model: busy for 3 cycles after each accepted start.
    int tx_cnt = 0;
    always @(posedge clk) begin
        if (tx_start && tx_cnt == 0) tx_cnt <= 3;
        else if (tx_cnt > 0)         tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = (tx_cnt != 0);

    int n_checks = 0;
    int n_fail = 0;
    int starts = 0;
    int dones = 0;
    logic [7:0] exp_q[$];
    logic prev_start = 1'b0, prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame model: what the response to a code must be given current inputs.
    function automatic logic [63:0] model_value(input logic [15:0] code, output bit known);
        known = 1'b1;
        case (code)
            16'd20: return {56'd0, estadoRx};
            16'd25: return {56'd0, controlDM};
            16'd26: return {32'd0, freq_sync};
            16'd27: return {32'd0, delay_pulse};
            16'd28: return {32'd0, width_pulse};
            16'd29: return {32'd0, delay_det};
            16'd30: return {32'd0, width_det};
            16'd33: return pixelColor;
            16'd35: return {32'd0, ireg_write};
            16'd36: return {32'd0, ireg_read};
            16'd41: return {56'd0, dead_time_APD};
            16'd42: return {48'd0, dataPoints};
            default: begin known = 1'b0; return 64'd0; end
        endcase
    endfunction

    function automatic logic [7:0] model_byte(input logic [15:0] code, input int i);
        logic [7:0] b [12];
        bit known;
        logic [63:0] v;
        v = model_value(code, known);
        b[0] = known ? 8'h01 : 8'hEE;
        for (int k = 0; k < 8; k++) b[1+k] = v[63-8*k -: 8];
        b[9]  = code[15:8];
        b[10] = code[7:0];
        b[11] = 8'h00;
        for (int k = 0; k < 11; k++) b[11] = b[11] ^ b[k];
        return b[i];
    endfunction

    task automatic push_frame(input logic [15:0] code);
        for (int i = 0; i < FRAME_N; i++) exp_q.push_back(model_byte(code, i));
    endtask

    // Per-cycle monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                starts++;
                check("tx_start while tx_busy", tx_busy, 1'b0);
                check("tx_start single cycle", prev_start, 1'b0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected tx_start: got data %0h, expected no start", tx_data);
                end else begin
                    check("tx_data", tx_data, exp_q.pop_front());
                end
            end
            if (done) begin
                dones++;
                check("busy low with done", busy, 1'b0);
                check("done single cycle", prev_done, 1'b0);
                check("bytes left at done", exp_q.size(), 0);
            end
        end
        prev_start = tx_start;
        prev_done  = done;
    end

    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        #1;
        check("done within budget", got, 1'b1);
    endtask

    task automatic wait_starts(input int target, input int budget);
        bit got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            #1;
            if (starts >= target) got = 1'b1;
        end
        check("tx_start count reached", got, 1'b1);
    endtask

    // Issue one request, check 2-cycle latency, perturb inputs after the
    // accepting edge, then wait for the frame to finish.
    task automatic run_frame(input logic [15:0] code);
        int s0, d0;
        @(negedge clk);
        s0 = starts;
        d0 = dones;
        req_code = code;
        req = 1'b1;
        push_frame(code);
        @(posedge clk);
        #1;
        req = 1'b0;
        req_code = 16'hFFFF;
        freq_sync = ~freq_sync;
        pixelColor = ~pixelColor;
        estadoRx = ~estadoRx;
        @(negedge clk);
        check("busy after accept", busy, 1'b1);
        check("no tx_start in LOAD", tx_start, 1'b0);
        @(negedge clk);
        check("first tx_start latency", tx_start, 1'b1);
        wait_done(400);
        check("tx_start count per frame", starts - s0, FRAME_N);
        check("done count per frame", dones - d0, 1);
        @(negedge clk);
        check("idle after done", busy, 1'b0);
    endtask

    logic [7:0] lit [11];
    int s_mark, quiet;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset tx_start", tx_start, 1'b0);
        check("reset tx_data", tx_data, 8'h00);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // freq_sync read-back.
        freq_sync = 32'h0000_C350;
        lit = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC3, 8'h50, 8'h00, 8'h1A};
        for (int i = 0; i < 11; i++) check("model pin code 26", model_byte(16'd26, i), lit[i]);
        run_frame(16'd26);

        // pixelColor read-back (full 64 bits).
        pixelColor = 64'h0123_4567_89AB_CDEF;
        lit = '{8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h21};
        for (int i = 0; i < 11; i++) check("model pin code 33", model_byte(16'd33, i), lit[i]);
        run_frame(16'd33);

        // Unknown code.
        lit = '{8'hEE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h63};
        for (int i = 0; i < 11; i++) check("model pin code 0x63", model_byte(16'h0063, i), lit[i]);
        run_frame(16'h0063);

        // Narrow registers and remaining map entries.
        controlDM = 8'hA5; dataPoints = 16'hBEEF; dead_time_APD = 8'h3C;
        ireg_read = 32'h1111_2222; ireg_write = 32'h3333_4444;
        run_frame(16'd25);
        run_frame(16'd42);
        run_frame(16'd41);
        run_frame(16'd36);
        run_frame(16'd35);

        // Second request mid-frame is ignored.
        delay_pulse = 32'h8765_4321;
        @(negedge clk);
        s_mark = starts;
        req_code = 16'd27;
        req = 1'b1;
        push_frame(16'd27);
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_starts(s_mark + 4, 200);
        req_code = 16'd26;
        req = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        req = 1'b0;
        wait_done(400);
        repeat (20) @(negedge clk);
        #1;
        check("ignored req: tx_start count", starts - s_mark, FRAME_N);
        check("ignored req: busy stays low", busy, 1'b0);

        // Reset after the 5th tx_start abandons the frame.
        width_pulse = 32'hCAFE_F00D;
        @(negedge clk);
        s_mark = starts;
        req_code = 16'd28;
        req = 1'b1;
        push_frame(16'd28);
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_starts(s_mark + 5, 200);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("mid reset tx_start", tx_start, 1'b0);
        check("mid reset busy", busy, 1'b0);
        check("mid reset done", done, 1'b0);
        check("mid reset tx_data", tx_data, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s_mark = starts;
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_start || busy || done) quiet++;
        end
        check("outputs quiet after reset", quiet, 0);
        check("no tx_start after reset", starts - s_mark, 0);
        delay_det = 32'h0000_00FF;
        run_frame(16'd29);

        // req held high: back-to-back frames with an idle gap.
        width_det = 32'h1234_5678;
        @(negedge clk);
        s_mark = starts;
        req_code = 16'd30;
        req = 1'b1;
        push_frame(16'd30);
        wait_done(400);
        push_frame(16'd30);
        @(negedge clk);
        check("idle gap between frames", busy, 1'b0);
        quiet = 0;
        for (int c = 0; c < 20 && !busy; c++) @(negedge clk);
        check("second frame accepted", busy, 1'b1);
        req = 1'b0;
        wait_done(400);
        repeat (20) @(negedge clk);
        #1;
        check("back-to-back tx_start count", starts - s_mark, 2 * FRAME_N);

`ifdef PARAM_TX_CHECKSUM_EN
        estadoRx = 8'h05;
        check("model pin checksum", model_byte(16'd20, 11), 8'h10);
        run_frame(16'd20);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
